// File: rtl/aclk_timegen_if.sv
// rtl/aclk_timegen_if.sv - control and pulse signals between the alarm-clock time base and its users
interface aclk_timegen_if;
  logic       reset_count;
  logic       fast_watch;
  logic       one_second;
  logic       one_minute;
  logic [5:0] sec_count;

  modport master (
    output reset_count,
    output fast_watch,
    input  one_second,
    input  one_minute,
    input  sec_count
  );

  modport slave (
    input  reset_count,
    input  fast_watch,
    output one_second,
    output one_minute,
    output sec_count
  );
endinterface

// File: rtl/aclk_timegen.sv
// rtl/aclk_timegen.sv - alarm-clock time base: prescaler, seconds counter, second/minute pulses
// Optional fast-watch mode (one_minute every second) is compiled in by ACLK_TIMEGEN_FAST_WATCH_EN.
module aclk_timegen #(
  parameter int CLK_PER_SEC = 256
) (
  input  logic          clk,
  input  logic          reset,
  aclk_timegen_if.slave bus
);

  localparam int            PW    = (CLK_PER_SEC > 2) ? $clog2(CLK_PER_SEC) : 1;
  localparam logic [PW-1:0] P_MAX = PW'(CLK_PER_SEC - 1);

  logic [PW-1:0] prescaler;
  logic [5:0]    sec_count;
  logic          one_second;
  logic          one_minute;
  logic          wrap;
  logic          fast;

`ifdef ACLK_TIMEGEN_FAST_WATCH_EN
  assign fast = bus.fast_watch;
`else
  logic unused_fast_watch;
  assign unused_fast_watch = bus.fast_watch;
  assign fast              = 1'b0;
`endif

  // reset_count suppresses the wrap so a restart never emits a pulse
  assign wrap = (prescaler == P_MAX) && !bus.reset_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prescaler  <= '0;
      sec_count  <= '0;
      one_second <= 1'b0;
      one_minute <= 1'b0;
    end else if (bus.reset_count) begin
      prescaler  <= '0;
      sec_count  <= '0;
      one_second <= 1'b0;
      one_minute <= 1'b0;
    end else begin
      prescaler  <= wrap ? '0 : prescaler + 1'b1;
      one_second <= wrap;
      if (fast) begin
        sec_count  <= '0;
        one_minute <= wrap;
      end else begin
        one_minute <= wrap && (sec_count == 6'd59);
        if (wrap)
          sec_count <= (sec_count == 6'd59) ? 6'd0 : sec_count + 6'd1;
      end
    end
  end

  assign bus.one_second = one_second;
  assign bus.one_minute = one_minute;
  assign bus.sec_count  = sec_count;

endmodule
